host_mailbox: RTL and testbench

//   Multi-channel tohost/fromhost mailbox snooping the core data-memory bus.

---
 rtl/host_mailbox_if.sv | 35 +++
 rtl/host_mailbox.sv | 209 ++++++++++++++++++++
 tb/tb_host_mailbox.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/host_mailbox_if.sv
// Bundle of core data-memory snoop, tohost stream, fromhost write and status
// signals for host_mailbox. Suffixes are from the mailbox's point of view.
interface host_mailbox_if #(
    parameter int CH_W = 2
) ();
    logic            dm_en_i;
    logic            dm_wen_i;
    logic [31:0]     dm_addr_i;
    logic [31:0]     dm_din_i;
    logic            dm_hit_o;
    logic [31:0]     dm_dout_o;
    logic            dm_stall_o;
    logic            th_valid_o;
    logic            th_ready_i;
    logic [CH_W-1:0] th_chan_o;
    logic [31:0]     th_data_o;
    logic            fh_wen_i;
    logic [31:0]     fh_data_i;
    logic            done_o;
    logic            pass_o;
    logic [30:0]     fail_code_o;
    logic            timeout_o;

    modport master (
        output dm_en_i, dm_wen_i, dm_addr_i, dm_din_i, th_ready_i, fh_wen_i, fh_data_i,
        input  dm_hit_o, dm_dout_o, dm_stall_o, th_valid_o, th_chan_o, th_data_o,
        input  done_o, pass_o, fail_code_o, timeout_o
    );

    modport slave (
        input  dm_en_i, dm_wen_i, dm_addr_i, dm_din_i, th_ready_i, fh_wen_i, fh_data_i,
        output dm_hit_o, dm_dout_o, dm_stall_o, th_valid_o, th_chan_o, th_data_o,
        output done_o, pass_o, fail_code_o, timeout_o
    );
endinterface

// File: rtl/host_mailbox.sv
// Multi-channel tohost/fromhost mailbox snooping the core data-memory bus:
// tohost FIFO with core back-pressure, shared fromhost word, pass/fail decode and watchdog.
module host_mailbox #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter logic [31:0] FROMHOST_ADDR  = 32'h8000_1040,
    parameter int          NUM_CH         = 4,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    host_mailbox_if.slave  bus
);
    localparam int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          EW      = CH_W + 32;
    localparam logic [31:0] TH_END  = TOHOST_ADDR + 32'(4 * NUM_CH);
    localparam bit          WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]     fromhost_q, fromhost_d;
    logic [31:0]     dout_q, dout_d;
    logic [31:0]     cnt_q, cnt_d;
    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [30:0]     fail_code_q, fail_code_d;
    logic            timeout_q, timeout_d;

    logic [31:0]     addr_word_s;
    logic            th_hit_s;
    logic            fh_hit_s;
    logic [CH_W-1:0] chan_s;
    logic            core_wr_s;
    logic            core_rd_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            stall_s;
    logic [EW-1:0]   head_s;

    // Address decode; byte offset within a tohost word is ignored.
    always_comb begin
        addr_word_s = {bus.dm_addr_i[31:2], 2'b00};
        th_hit_s    = 1'b0;
        fh_hit_s    = 1'b0;
        chan_s      = bus.dm_addr_i[CH_W+1:2];
        if ((addr_word_s >= TOHOST_ADDR) && (addr_word_s < TH_END)) begin
            th_hit_s = 1'b1;
        end else begin
            th_hit_s = 1'b0;
        end
        if (bus.dm_addr_i == FROMHOST_ADDR) begin
            fh_hit_s = 1'b1;
        end else begin
            fh_hit_s = 1'b0;
        end
    end

    // FIFO flags and push/pop/stall qualification.
    always_comb begin
        core_wr_s = bus.dm_en_i & bus.dm_wen_i;
        core_rd_s = bus.dm_en_i & ~bus.dm_wen_i;
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push_s    = core_wr_s & th_hit_s & ~full_s;
        stall_s   = core_wr_s & th_hit_s & full_s;
        pop_s     = ~empty_s & bus.th_ready_i;
        head_s    = mem_q[rd_ptr_q[PW-1:0]];
    end

    // Pointer next-state; pointers carry a wrap bit and roll over naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO storage and pointers; contents are cleared so head fields read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[PW-1:0]] <= {chan_s, bus.dm_din_i};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Fromhost word (bench write beats core write) and 1-cycle read data.
    always_comb begin
        fromhost_d = fromhost_q;
        dout_d     = dout_q;
        if (bus.fh_wen_i) begin
            fromhost_d = bus.fh_data_i;
        end else if (core_wr_s && fh_hit_s) begin
            fromhost_d = bus.dm_din_i;
        end else begin
            fromhost_d = fromhost_q;
        end
        if (core_rd_s && (th_hit_s || fh_hit_s)) begin
            if (fh_hit_s) begin
                dout_d = fromhost_q;
            end else begin
                dout_d = 32'd0;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // Status FSM and watchdog; completion takes priority over expiry.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (push_s) begin
                    cnt_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (push_s && (chan_s == {CH_W{1'b0}}) && bus.dm_din_i[0]) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    pass_d      = (bus.dm_din_i == 32'd1);
                    fail_code_d = bus.dm_din_i[31:1];
                end else if (WD_EN && (cnt_q == WD_LAST)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_TIMEOUT: begin
                state_d = ST_TIMEOUT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Fromhost, read data, status and watchdog registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fromhost_q  <= 32'd0;
            dout_q      <= 32'd0;
            cnt_q       <= 32'd0;
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= 31'd0;
            timeout_q   <= 1'b0;
        end else begin
            fromhost_q  <= fromhost_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.dm_hit_o    = bus.dm_en_i & (th_hit_s | fh_hit_s);
    assign bus.dm_stall_o  = stall_s;
    assign bus.dm_dout_o   = dout_q;
    assign bus.th_valid_o  = ~empty_s;
    assign bus.th_chan_o   = head_s[EW-1:32];
    assign bus.th_data_o   = head_s[31:0];
    assign bus.done_o      = done_q;
    assign bus.pass_o      = pass_q;
    assign bus.fail_code_o = fail_code_q;
    assign bus.timeout_o   = timeout_q;
endmodule

// File: tb/tb_host_mailbox.sv
// Self-checking bench for host_mailbox: directed scenarios plus randomized bus
// traffic, all compared against a queue-based behavioural model.
module tb_host_mailbox;
    localparam logic [31:0] TH    = 32'h8000_1000;
    localparam logic [31:0] FH    = 32'h8000_1040;
    localparam int          DEPTH = 4;
    localparam int          TO    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    host_mailbox_if #(.CH_W(2)) bus_if ();

    host_mailbox #(
        .TOHOST_ADDR(TH), .FROMHOST_ADDR(FH), .NUM_CH(4),
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus_if.slave)
    );

    typedef struct packed { logic [1:0] chan; logic [31:0] data; } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fh, m_dout, m_idle;
    int          m_state;           // 0 running, 1 finished, 2 expired
    logic        m_done, m_pass, m_to;
    logic [30:0] m_fail;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w >= TH) && (w < TH + 32'd16);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fh = 32'd0; m_dout = 32'd0; m_idle = 32'd0; m_state = 0;
        m_done = 1'b0; m_pass = 1'b0; m_to = 1'b0; m_fail = 31'd0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, {63'd0, bus_if.th_valid_o}, {63'd0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            check({tag, "_chan"}, {62'd0, bus_if.th_chan_o}, {62'd0, mq[0].chan});
            check({tag, "_data"}, {32'd0, bus_if.th_data_o}, {32'd0, mq[0].data});
        end
        check({tag, "_dout"}, {32'd0, bus_if.dm_dout_o}, {32'd0, m_dout});
        check({tag, "_done"}, {63'd0, bus_if.done_o}, {63'd0, m_done});
        check({tag, "_pass"}, {63'd0, bus_if.pass_o}, {63'd0, m_pass});
        check({tag, "_fail"}, {33'd0, bus_if.fail_code_o}, {33'd0, m_fail});
        check({tag, "_tmo"}, {63'd0, bus_if.timeout_o}, {63'd0, m_to});
    endtask

    task automatic idle();
        bus_if.dm_en_i = 1'b0; bus_if.dm_wen_i = 1'b0;
        bus_if.dm_addr_i = 32'd0; bus_if.dm_din_i = 32'd0;
        bus_if.fh_wen_i = 1'b0; bus_if.fh_data_i = 32'd0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.dm_en_i = 1'b1; bus_if.dm_wen_i = 1'b1;
        bus_if.dm_addr_i = a; bus_if.dm_din_i = d;
    endtask

    task automatic read(input logic [31:0] a);
        bus_if.dm_en_i = 1'b1; bus_if.dm_wen_i = 1'b0;
        bus_if.dm_addr_i = a; bus_if.dm_din_i = 32'd0;
    endtask

    // One clock: check comb outputs, advance the model, check registered outputs.
    task automatic tick();
        logic        en, wr, th, fh, full, push, pop;
        logic [31:0] a, d, off;
        ent_t        e;
        #1;
        en = bus_if.dm_en_i; wr = en & bus_if.dm_wen_i;
        a = bus_if.dm_addr_i; d = bus_if.dm_din_i;
        th = in_win(a); fh = (a == FH);
        full = (mq.size() == DEPTH);
        push = wr & th & ~full;
        pop  = (mq.size() > 0) & bus_if.th_ready_i;
        off = ({a[31:2], 2'b00} - TH) >> 2;
        e.chan = off[1:0]; e.data = d;
        check("dm_hit", {63'd0, bus_if.dm_hit_o}, {63'd0, en & (th | fh)});
        check("dm_stall", {63'd0, bus_if.dm_stall_o}, {63'd0, wr & th & full});
        if (en && !bus_if.dm_wen_i && (th || fh)) m_dout = fh ? m_fh : 32'd0;
        if (bus_if.fh_wen_i) m_fh = bus_if.fh_data_i;
        else if (wr && fh) m_fh = d;
        if (m_state == 0) begin
            if (push && e.chan == 2'd0 && d[0]) begin
                m_state = 1; m_done = 1'b1; m_pass = (d == 32'd1); m_fail = d[31:1];
            end else if (m_idle == TO - 1) begin
                m_state = 2; m_to = 1'b1;
            end
            m_idle = push ? 32'd0 : m_idle + 32'd1;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        idle();
        bus_if.th_ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp3 [5];
        logic [31:0] d;
        int          cyc, sel;
        idle();
        bus_if.th_ready_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Pass on channel 0.
        store(TH, 32'd1); tick(); idle();
        check("t1_valid", {63'd0, bus_if.th_valid_o}, 64'd1);
        check("t1_chan", {62'd0, bus_if.th_chan_o}, 64'd0);
        check("t1_data", {32'd0, bus_if.th_data_o}, 64'd1);
        check("t1_pass", {62'd0, bus_if.done_o, bus_if.pass_o}, 64'd3);
        tick();

        // Fail code, then frozen status.
        do_reset();
        store(TH, 32'd7); tick();
        check("t2_fail", {31'd0, bus_if.done_o, bus_if.pass_o, bus_if.fail_code_o}, {31'd0, 1'b1, 1'b0, 31'd3});
        store(TH, 32'd1); tick(); idle();
        check("t2_frozen", {63'd0, bus_if.pass_o}, 64'd0);

        // Fill, stall, ordered drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            store(TH + 32'd8, 32'h10 + 32'(i)); tick();
        end
        store(TH + 32'd8, 32'h99);
        #1;
        check("t3_stall", {63'd0, bus_if.dm_stall_o}, 64'd1);
        tick();
        exp3[0] = 32'h10; exp3[1] = 32'h11; exp3[2] = 32'h12; exp3[3] = 32'h13; exp3[4] = 32'h99;
        bus_if.th_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t3_order", {32'd0, bus_if.th_data_o}, {32'd0, exp3[k]});
            check("t3_chan", {62'd0, bus_if.th_chan_o}, 64'd2);
            tick();
            if (k == 1) idle();
        end
        check("t3_empty", {63'd0, bus_if.th_valid_o}, 64'd0);

        // Fromhost write collision and reads.
        do_reset();
        bus_if.fh_wen_i = 1'b1; bus_if.fh_data_i = 32'hCAFE;
        store(FH, 32'h1234); tick(); idle();
        read(FH); tick(); idle();
        check("t4_rd", {32'd0, bus_if.dm_dout_o}, 64'hCAFE);
        tick();
        check("t4_hold", {32'd0, bus_if.dm_dout_o}, 64'hCAFE);
        read(TH + 32'd4); tick(); idle();
        check("t4_th_rd", {32'd0, bus_if.dm_dout_o}, 64'd0);

        // Watchdog expiry, undisturbed then delayed by a store.
        do_reset();
        cyc = 0;
        while (bus_if.timeout_o !== 1'b1 && cyc < 40) begin
            tick(); cyc++;
        end
        check("t5_expiry", 64'(cyc), 64'd16);
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        store(TH + 32'd4, 32'd5); tick(); idle();
        cyc = 10;
        while (bus_if.timeout_o !== 1'b1 && cyc < 60) begin
            tick(); cyc++;
        end
        check("t5_delayed", 64'(cyc), 64'd26);

        // Asynchronous reset mid-operation.
        do_reset();
        store(TH + 32'd4, 32'd3); tick();
        store(TH + 32'd4, 32'd4); tick();
        store(TH, 32'd1); tick(); idle();
        check("t6_pre", {62'd0, bus_if.done_o, bus_if.th_valid_o}, 64'd3);
        do_reset();
        store(TH + 32'd12, 32'hAB); tick(); idle();
        check("t6_alone", {32'd0, bus_if.th_data_o}, 64'hAB);
        bus_if.th_ready_i = 1'b1; tick();
        check("t6_drained", {63'd0, bus_if.th_valid_o}, 64'd0);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int n = 0; n < 100; n++) begin
                sel = $urandom_range(0, 7);
                case (sel)
                    4:       bus_if.dm_addr_i = FH;
                    5:       bus_if.dm_addr_i = TH - 32'd4;
                    6:       bus_if.dm_addr_i = TH + 32'd16;
                    7:       bus_if.dm_addr_i = $urandom;
                    default: bus_if.dm_addr_i = TH + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
                endcase
                d = $urandom;
                if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
                if ($urandom_range(0, 9) == 0) d = 32'd1;
                bus_if.dm_din_i   = d;
                bus_if.dm_en_i    = ($urandom_range(0, 3) != 0);
                bus_if.dm_wen_i   = $urandom_range(0, 1) == 1;
                bus_if.th_ready_i = $urandom_range(0, 1) == 1;
                bus_if.fh_wen_i   = ($urandom_range(0, 7) == 0);
                bus_if.fh_data_i  = $urandom;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
